fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_unit_if.sv | 24 ++
 rtl/fetch_pc_unit.sv | 75 +++++++
 tb/tb_fetch_pc_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch unit bus: control inputs from later stages, instruction-memory port and
// the decode (D) register outputs.
interface fetch_pc_unit_if;
  logic        stall_i;
  logic        redirect_i;
  logic [9:0]  redirect_pc_i;
  logic        halt_i;
  logic [31:0] f_instr_i;
  logic [9:0]  pc_o;
  logic [9:0]  D_pc_o;
  logic [31:0] D_instr_o;
  logic        D_valid_o;
  logic        halted_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, halt_i, f_instr_i,
    output pc_o, D_pc_o, D_instr_o, D_valid_o, halted_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, halt_i, f_instr_i,
    input  pc_o, D_pc_o, D_instr_o, D_valid_o, halted_o
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with a single decode pipeline register.
// Handles redirect/flush, halt and stall; all outputs come straight from flops.
module fetch_pc_unit #(
  parameter logic [9:0]  RESET_PC  = 10'h000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fetch_pc_unit_if.master  bus
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [9:0]  d_pc_q, d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic        d_valid_q, d_valid_d;

  // Redirect targets are word aligned; the low address bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc_i[1:0];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    d_pc_d    = d_pc_q;
    d_instr_d = d_instr_q;
    d_valid_d = d_valid_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (bus.redirect_i) begin
          pc_d      = {bus.redirect_pc_i[9:2], 2'b00};
          d_instr_d = NOP_INSTR;
          d_valid_d = 1'b0;
        end else if (bus.halt_i) begin
          state_d   = StHalt;
          d_instr_d = NOP_INSTR;
          d_valid_d = 1'b0;
        end else if (!bus.stall_i) begin
          d_instr_d = bus.f_instr_i;
          d_pc_d    = pc_q;
          d_valid_d = 1'b1;
          pc_d      = pc_q + 10'd4;
        end
      end
      StHalt: ;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StBoot;
      pc_q      <= RESET_PC;
      d_pc_q    <= 10'h000;
      d_instr_q <= NOP_INSTR;
      d_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      d_pc_q    <= d_pc_d;
      d_instr_q <= d_instr_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign bus.pc_o      = pc_q;
  assign bus.D_pc_o    = d_pc_q;
  assign bus.D_instr_o = d_instr_q;
  assign bus.D_valid_o = d_valid_q;
  assign bus.halted_o  = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: a cycle-level reference model pushes the
// expected outputs per cycle, and a negedge monitor pops and compares them.
module tb_fetch_pc_unit;

  localparam logic [31:0] Nop = 32'h00000013;

  typedef struct packed {
    logic [9:0]  pc;
    logic [9:0]  dpc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
  } snap_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC  (10'h000),
    .NOP_INSTR (Nop)
  ) u_dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic        in_stall = 1'b0, in_redirect = 1'b0, in_halt = 1'b0;
  logic [9:0]  in_rpc = 10'h000;

  assign bus.stall_i       = in_stall;
  assign bus.redirect_i    = in_redirect;
  assign bus.redirect_pc_i = in_rpc;
  assign bus.halt_i        = in_halt;
  assign bus.f_instr_i     = mem[bus.pc_o[9:2]];

  // Reference model: mode 0 = boot, 1 = running, 2 = halted.
  int          m_mode;
  logic [9:0]  m_pc, m_dpc;
  logic [31:0] m_instr;
  logic        m_valid;

  snap_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void model_reset();
    m_mode  = 0;
    m_pc    = 10'h000;
    m_dpc   = 10'h000;
    m_instr = Nop;
    m_valid = 1'b0;
  endfunction

  function automatic void model_edge();
    int next_pc;
    if (!rst_i) return;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (in_redirect) begin
        m_pc    = 10'((in_rpc / 4) * 4);
        m_instr = Nop;
        m_valid = 1'b0;
      end else if (in_halt) begin
        m_mode  = 2;
        m_instr = Nop;
        m_valid = 1'b0;
      end else if (!in_stall) begin
        m_instr = mem[m_pc / 4];
        m_dpc   = m_pc;
        m_valid = 1'b1;
        next_pc = (int'(m_pc) + 4) % 1024;
        m_pc    = 10'(next_pc);
      end
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.pc     = m_pc;
    s.dpc    = m_dpc;
    s.instr  = m_instr;
    s.valid  = m_valid;
    s.halted = (m_mode == 2);
    return s;
  endfunction

  // One clock: model takes the edge, then new inputs go on (reset acts at once).
  task automatic step(input logic r, input logic st, input logic rd,
                      input logic [9:0] rp, input logic hl);
    @(posedge clk_i);
    model_edge();
    #1;
    rst_i       = r;
    in_stall    = st;
    in_redirect = rd;
    in_rpc      = rp;
    in_halt     = hl;
    if (!r) model_reset();
    sb.push_back(model_snap());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
  endtask

  always @(negedge clk_i) begin
    snap_t exp_s, act_s;
    if (sb.size() > 0) begin
      exp_s        = sb.pop_front();
      act_s.pc     = bus.pc_o;
      act_s.dpc    = bus.D_pc_o;
      act_s.instr  = bus.D_instr_o;
      act_s.valid  = bus.D_valid_o;
      act_s.halted = bus.halted_o;
      checks++;
      if (act_s !== exp_s) begin
        errors++;
        $display("FAIL cycle_check t=%0t: got pc=%h dpc=%h instr=%h v=%b h=%b, want pc=%h dpc=%h instr=%h v=%b h=%b",
                 $time, act_s.pc, act_s.dpc, act_s.instr, act_s.valid, act_s.halted,
                 exp_s.pc, exp_s.dpc, exp_s.instr, exp_s.valid, exp_s.halted);
      end
    end
  end

  initial begin
    logic r, st, rd, hl;
    for (int i = 0; i < 256; i++) mem[i] = 32'h000000A0 + 32'(i * 4);
    model_reset();

    // Reset held, then release and free-run through the boot cycle.
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    run(3);
    // Two-cycle stall, then advance.
    step(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    run(3);
    // Redirect beats simultaneous stall and halt.
    step(1'b1, 1'b1, 1'b1, 10'h123, 1'b1);
    run(3);
    // Halt, redirect ignored while halted, then reset.
    step(1'b1, 1'b0, 1'b0, 10'h000, 1'b1);
    step(1'b1, 1'b0, 1'b1, 10'h040, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'h000, 1'b1);
    run(2);
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    run(2);
    // Redirect near the top of the address space and wrap.
    step(1'b1, 1'b0, 1'b1, 10'h3F8, 1'b0);
    run(5);
    // Reset asserted between edges while running.
    step(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    run(2);

    // Randomized traffic over random memory contents.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 39) != 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      hl = ($urandom_range(0, 29) == 0);
      step(r, st, rd, 10'($urandom), hl);
    end

    @(negedge clk_i);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
